ram_stream_reader: RTL

Read-side controller for a single port of the team's synchronous-read block RAM wrapper. It accepts a burst command (base address, length), drives the RAM port's enable and address, and absorbs the fixed RAM read latency. Read data is presented as a valid/ready stream with full backpressure support and one word per cycle sustained throughput. It sits between a RAM port (e.g. coefficient or sample tables) and a downstream datapath consumer.

---
 rtl/ram_stream_reader_pkg.sv | 23 ++
 rtl/ram_stream_reader_fifo.sv | 56 +++++
 rtl/ram_stream_reader.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/ram_stream_reader_pkg.sv
// Shared types and sizing helpers for the RAM stream reader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ram_stream_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Two spare slots beyond the RAM pipeline keep one-word-per-cycle flow
    // while a credit returns.
    function automatic int fifo_depth(input int read_latency);
        return read_latency + 2;
    endfunction

    // Credit counter must hold 0..FIFO_DEPTH inclusive.
    function automatic int credit_width(input int read_latency);
        return $clog2(read_latency + 3);
    endfunction

endpackage

// File: rtl/ram_stream_reader_fifo.sv
// Small synchronous FIFO holding returned RAM words with their last flag.
// Latency: a write is visible on rd_vld_o/rd_dat_o the cycle after it lands.
// Backpressure: none on the write side; the caller's credits prevent overflow.
module ram_stream_reader_fifo #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_dat_i,
    input  logic             rd_en_i,
    output logic             rd_vld_o,
    output logic [WIDTH-1:0] rd_dat_o
);

    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CNTW-1:0]  cnt_q;
    logic             rd_fire;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign rd_vld_o = (cnt_q != '0);
    assign rd_fire  = rd_en_i & rd_vld_o;
    // Head word comes straight from storage flops, so it is stable while stalled.
    assign rd_dat_o = mem_q[rd_ptr_q];

    // Storage, pointers and occupancy; storage is cleared so outputs read zero after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (wr_en_i) begin
                mem_q[wr_ptr_q] <= wr_dat_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (rd_fire) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            cnt_q <= cnt_q + CNTW'(wr_en_i) - CNTW'(rd_fire);
        end
    end

endmodule

// File: rtl/ram_stream_reader.sv
// Burst read controller: issues RAM reads and streams the words out valid/ready.
// Latency: first ram_en one cycle after start, first m_valid READ_LATENCY+2 cycles after start.
// Backpressure: credit counter stalls ram_en once in-flight + buffered words reach FIFO depth.
// Optional looping build: define RAM_STREAM_READER_LOOP_EN to add the loop input.
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 7,
    parameter int DATA_WIDTH    = 16,
    parameter int RAM_SIZE      = 128,
    parameter int READ_LATENCY  = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [ADDRESS_WIDTH-1:0]     base_addr,
    input  logic [ADDRESS_WIDTH:0]       len,
`ifdef RAM_STREAM_READER_LOOP_EN
    input  logic                         loop,
`endif
    output logic                         busy,
    output logic                         done,
    output logic                         ram_en,
    output logic [ADDRESS_WIDTH-1:0]     ram_addr,
    input  logic signed [DATA_WIDTH-1:0] ram_do,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic signed [DATA_WIDTH-1:0] m_data,
    output logic                         m_last
);

    localparam int FIFO_DEPTH = fifo_depth(READ_LATENCY);
    localparam int CW         = credit_width(READ_LATENCY);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(RAM_SIZE - 1);
    localparam logic [ADDRESS_WIDTH:0]   REM_ONE   = (ADDRESS_WIDTH + 1)'(1);

    state_e                    state_q, state_d;
    logic [ADDRESS_WIDTH-1:0]  addr_q, addr_d;
    logic [ADDRESS_WIDTH-1:0]  ram_addr_q;
    logic [ADDRESS_WIDTH:0]    rem_q, rem_d;
    logic [CW-1:0]             cred_q, cred_d;
    logic                      done_q, done_d;
    logic [READ_LATENCY-1:0]   vld_sr_q;
    logic [READ_LATENCY-1:0]   last_sr_q;
    logic                      issue;
    logic                      pass_end;
    logic                      pop;
    logic                      fifo_vld;
    logic [DATA_WIDTH:0]       fifo_dat;

`ifdef RAM_STREAM_READER_LOOP_EN
    logic [ADDRESS_WIDTH-1:0]  base_q;
    logic [ADDRESS_WIDTH:0]    len_q;

    // Keep the command so each looped pass can restart from the base address.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base_q <= '0;
            len_q  <= '0;
        end else if (state_q == IDLE && start) begin
            base_q <= base_addr;
            len_q  <= len;
        end
    end
`endif

    // A read may only go out while a FIFO slot is guaranteed for its data.
    assign issue    = (state_q == READ) && (cred_q < CW'(FIFO_DEPTH));
    assign pass_end = issue && (rem_q == REM_ONE);
    assign pop      = fifo_vld & m_ready;

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign ram_en   = issue;
    assign ram_addr = issue ? addr_q : ram_addr_q;
    assign cred_d   = cred_q + CW'(issue) - CW'(pop);

    // Next-state, address and remaining-count logic.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = READ;
                        addr_d  = base_addr;
                        rem_d   = len;
                    end
                end
            end
            READ: begin
                if (issue) begin
                    addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
                    rem_d  = rem_q - REM_ONE;
                    if (rem_q == REM_ONE) begin
`ifdef RAM_STREAM_READER_LOOP_EN
                        if (loop) begin
                            addr_d = base_q;
                            rem_d  = len_q;
                        end else begin
                            state_d = DRAIN;
                        end
`else
                        state_d = DRAIN;
`endif
                    end
                end
            end
            DRAIN: begin
                // Nothing else is in flight once the credit count is one,
                // so this pop is the closing word of the final pass.
                if (pop && cred_q == CW'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            ram_addr_q <= '0;
            rem_q      <= '0;
            cred_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            ram_addr_q <= ram_addr;
            rem_q      <= rem_d;
            cred_q     <= cred_d;
            done_q     <= done_d;
        end
    end

    // Delay each issue (and its last flag) to the cycle its data is on ram_do.
    generate
        if (READ_LATENCY == 1) begin : g_lat1
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    vld_sr_q  <= '0;
                    last_sr_q <= '0;
                end else begin
                    vld_sr_q  <= issue;
                    last_sr_q <= pass_end;
                end
            end
        end else begin : g_latn
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    vld_sr_q  <= '0;
                    last_sr_q <= '0;
                end else begin
                    vld_sr_q  <= {vld_sr_q[READ_LATENCY-2:0], issue};
                    last_sr_q <= {last_sr_q[READ_LATENCY-2:0], pass_end};
                end
            end
        end
    endgenerate

    ram_stream_reader_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en_i  (vld_sr_q[READ_LATENCY-1]),
        .wr_dat_i ({last_sr_q[READ_LATENCY-1], ram_do}),
        .rd_en_i  (m_ready),
        .rd_vld_o (fifo_vld),
        .rd_dat_o (fifo_dat)
    );

    assign m_valid = fifo_vld;
    assign m_data  = fifo_dat[DATA_WIDTH-1:0];
    assign m_last  = fifo_vld & fifo_dat[DATA_WIDTH];

endmodule
